// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder: lane width, accumulator width
// and the feeder's job-sequencing states.
package sa_pkg;
  localparam int DATA_W = 8;
  localparam int SUM_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WLOAD  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FIN    = 3'd4
  } state_t;
endpackage

// File: rtl/sa_skew_line.sv
// Per-row skew delay: DEPTH register stages carrying a data lane and its active flag.
// DEPTH=0 passes the feeder's common output register straight through.
module sa_skew_line
  import sa_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     act_in,
  output logic signed [DATA_W-1:0] dout,
  output logic                     act_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = clock ^ reset;
      assign dout       = din;
      assign act_out    = act_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] data_p [DEPTH];
      logic        [DEPTH-1:0]  act_p;

      // Bubbles (act=0, data=0) shift through exactly like real samples.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) data_p[i] <= '0;
          act_p <= '0;
        end else begin
          data_p[0] <= din;
          act_p[0]  <= act_in;
          for (int i = 1; i < DEPTH; i++) begin
            data_p[i] <= data_p[i-1];
            act_p[i]  <= act_p[i-1];
          end
        end
      end

      assign dout    = data_p[DEPTH-1];
      assign act_out = act_p[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_feeder.sv
// Systolic-array feeder: loads ROWS weight vectors, streams num_vecs skewed data vectors,
// drains the array and pulses done. Define SA_FEEDER_WREUSE_EN to add keep_w (skip weight load).
module sa_feeder
  import sa_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            num_vecs,
`ifdef SA_FEEDER_WREUSE_EN
  input  logic                   keep_w,
`endif
  input  logic                   w_valid,
  input  logic [DATA_W*COLS-1:0] w_data,
  output logic                   w_ready,
  input  logic                   d_valid,
  input  logic [DATA_W*ROWS-1:0] d_data,
  output logic                   d_ready,
  output logic [DATA_W*COLS-1:0] sa_win,
  output logic                   sa_wwrite,
  output logic [DATA_W*ROWS-1:0] sa_data,
  output logic [ROWS-1:0]        sa_active,
  output logic                   busy,
  output logic                   done
);

  localparam int WCW = $clog2(ROWS) + 1;
  localparam int DCW = $clog2(ROWS + COLS) + 1;
  localparam logic [WCW-1:0] W_LAST = WCW'(ROWS - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(ROWS + COLS - 2);

  state_t         state;
  logic [15:0]    nv;
  logic [15:0]    vcnt;
  logic [WCW-1:0] wcnt;
  logic [DCW-1:0] dcnt;
  logic           w_fire;
  logic           d_fire;

  assign w_ready = (state == WLOAD);
  assign d_ready = (state == STREAM);
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign w_fire  = w_valid && w_ready;
  assign d_fire  = d_valid && d_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      nv    <= '0;
      vcnt  <= '0;
      wcnt  <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nv   <= num_vecs;
            vcnt <= '0;
            wcnt <= '0;
            dcnt <= '0;
`ifdef SA_FEEDER_WREUSE_EN
            if (keep_w) state <= (num_vecs == 16'd0) ? DRAIN : STREAM;
            else
`endif
            state <= WLOAD;
          end
        end
        WLOAD: begin
          if (w_fire) begin
            if (wcnt == W_LAST) begin
              wcnt  <= '0;
              state <= (nv == 16'd0) ? DRAIN : STREAM;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        STREAM: begin
          // nv is nonzero here, so nv-1 never underflows and vcnt tops out at nv.
          if (d_fire) begin
            vcnt <= vcnt + 16'd1;
            if (vcnt == nv - 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) state <= FIN;
          else dcnt <= dcnt + 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Weight path: one registered write per accepted weight vector.
  always_ff @(posedge clock) begin
    if (reset) begin
      sa_win    <= '0;
      sa_wwrite <= 1'b0;
    end else begin
      sa_wwrite <= w_fire;
      if (w_fire) sa_win <= w_data;
    end
  end

  // Stage p0: common data register; idle cycles enter the skew as zero bubbles.
  logic signed [DATA_W-1:0] d_p0 [ROWS];
  logic                     act_p0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) d_p0[r] <= '0;
      act_p0 <= 1'b0;
    end else begin
      act_p0 <= d_fire;
      for (int r = 0; r < ROWS; r++)
        d_p0[r] <= d_fire ? $signed(d_data[r*DATA_W +: DATA_W]) : '0;
    end
  end

  // Stage p1..pROWS-1: row r is delayed r further cycles.
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic signed [DATA_W-1:0] lane_out;
      sa_skew_line #(.DEPTH(r)) u_skew (
        .clock   (clock),
        .reset   (reset),
        .din     (d_p0[r]),
        .act_in  (act_p0),
        .dout    (lane_out),
        .act_out (sa_active[r])
      );
      assign sa_data[r*DATA_W +: DATA_W] = lane_out;
    end
  endgenerate

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder with ROWS=COLS=4.
module tb_sa_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_vecs;
`ifdef SA_FEEDER_WREUSE_EN
  logic        keep_w;
`endif
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic        d_valid;
  logic [31:0] d_data;
  logic        d_ready;
  logic [31:0] sa_win;
  logic        sa_wwrite;
  logic [31:0] sa_data;
  logic [3:0]  sa_active;
  logic        busy;
  logic        done;

  int   npass = 0;
  int   ntotal = 0;
  int   n;
  logic wwr_seen, wr_seen, dr_seen, done_seen;

  sa_feeder #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .num_vecs  (num_vecs),
`ifdef SA_FEEDER_WREUSE_EN
    .keep_w    (keep_w),
`endif
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .d_valid   (d_valid),
    .d_data    (d_data),
    .d_ready   (d_ready),
    .sa_win    (sa_win),
    .sa_wwrite (sa_wwrite),
    .sa_data   (sa_data),
    .sa_active (sa_active),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic load_w(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      w_valid = 1'b1;
      w_data  = base + 32'(i);
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
      wwr_seen |= sa_wwrite;
      wr_seen  |= w_ready;
      dr_seen  |= d_ready;
    end while (!done && cnt < limit);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_win"},    sa_win, 32'h0);
    check({tag, "_wwrite"}, 32'(sa_wwrite), 32'h0);
    check({tag, "_data"},   sa_data, 32'h0);
    check({tag, "_active"}, 32'(sa_active), 32'h0);
    check({tag, "_busy"},   32'(busy), 32'h0);
    check({tag, "_done"},   32'(done), 32'h0);
    check({tag, "_wready"}, 32'(w_ready), 32'h0);
    check({tag, "_dready"}, 32'(d_ready), 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_vecs = '0;
    w_valid = 1'b0; w_data = '0; d_valid = 1'b0; d_data = '0;
`ifdef SA_FEEDER_WREUSE_EN
    keep_w = 1'b0;
`endif
    wwr_seen = 1'b0; wr_seen = 1'b0; dr_seen = 1'b0; done_seen = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Job 1: weights 1..4 back-to-back, two vectors back-to-back.
    start = 1'b1; num_vecs = 16'd2;
    tick();
    start = 1'b0;
    check("j1_busy", 32'(busy), 32'h1);
    check("j1_wready", 32'(w_ready), 32'h1);
    check("j1_dready_wload", 32'(d_ready), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      w_valid = 1'b1;
      w_data  = 32'h01010101 * i;
      tick();
      check("j1_wwrite", 32'(sa_wwrite), 32'h1);
      check("j1_win", sa_win, 32'h01010101 * i);
    end
    w_valid = 1'b0;
    check("j1_dready_stream", 32'(d_ready), 32'h1);
    check("j1_wready_stream", 32'(w_ready), 32'h0);
    d_valid = 1'b1; d_data = 32'h281E140A;
    tick();
    check("j1_wwrite_off", 32'(sa_wwrite), 32'h0);
    check("j1_e0_data", sa_data, 32'h0000000A);
    check("j1_e0_act", 32'(sa_active), 32'h1);
    d_data = 32'h291F150B;
    tick();
    d_valid = 1'b0;
    check("j1_e1_data", sa_data, 32'h0000140B);
    check("j1_e1_act", 32'(sa_active), 32'h3);
    check("j1_e1_dready", 32'(d_ready), 32'h0);
    tick();
    check("j1_e2_data", sa_data, 32'h001E1500);
    check("j1_e2_act", 32'(sa_active), 32'h6);
    tick();
    check("j1_e3_data", sa_data, 32'h281F0000);
    check("j1_e3_act", 32'(sa_active), 32'hC);
    tick();
    check("j1_e4_data", sa_data, 32'h29000000);
    check("j1_e4_act", 32'(sa_active), 32'h8);
    tick();
    check("j1_e5_data", sa_data, 32'h0);
    check("j1_e5_act", 32'(sa_active), 32'h0);
    wait_done(20, n);
    check("j1_done_lat", 32'(n), 32'd3);
    check("j1_fin_busy", 32'(busy), 32'h1);
    tick();
    check("j1_done_pulse", 32'(done), 32'h0);
    check("j1_idle_busy", 32'(busy), 32'h0);

    // Job 2: weight gap, then vectors with a one-cycle bubble between them.
    start = 1'b1; num_vecs = 16'd2;
    tick();
    start = 1'b0;
    w_valid = 1'b1; w_data = 32'h80FF7F01;
    tick();
    check("j2_w0_wwrite", 32'(sa_wwrite), 32'h1);
    w_valid = 1'b0; w_data = 32'hDEADBEEF;
    tick();
    check("j2_gap_wwrite", 32'(sa_wwrite), 32'h0);
    check("j2_gap_win", sa_win, 32'h80FF7F01);
    check("j2_gap_wready", 32'(w_ready), 32'h1);
    w_valid = 1'b1; w_data = 32'h00000002;
    tick();
    w_data = 32'h00000003;
    tick();
    w_data = 32'h00000004;
    tick();
    w_valid = 1'b0;
    check("j2_w3_win", sa_win, 32'h00000004);
    check("j2_dready", 32'(d_ready), 32'h1);
    d_valid = 1'b1; d_data = 32'h04030201;
    tick();
    check("j2_e0_data", sa_data, 32'h00000001);
    check("j2_e0_act", 32'(sa_active), 32'h1);
    d_valid = 1'b0;
    tick();
    check("j2_e1_data", sa_data, 32'h00000200);
    check("j2_e1_act", 32'(sa_active), 32'h2);
    d_valid = 1'b1; d_data = 32'h08070605;
    tick();
    d_valid = 1'b0;
    check("j2_e2_data", sa_data, 32'h00030005);
    check("j2_e2_act", 32'(sa_active), 32'h5);
    tick();
    check("j2_e3_data", sa_data, 32'h04000600);
    check("j2_e3_act", 32'(sa_active), 32'hA);
    tick();
    check("j2_e4_data", sa_data, 32'h00070000);
    check("j2_e4_act", 32'(sa_active), 32'h4);
    tick();
    check("j2_e5_data", sa_data, 32'h08000000);
    check("j2_e5_act", 32'(sa_active), 32'h8);
    wait_done(20, n);
    check("j2_done_lat", 32'(n), 32'd4);
    tick();

    // Job 3: num_vecs=0 goes straight to drain; start during drain is ignored.
    start = 1'b1; num_vecs = 16'd0;
    tick();
    start = 1'b0;
    load_w(32'h10203040);
    check("j3_drain_dready", 32'(d_ready), 32'h0);
    check("j3_drain_wready", 32'(w_ready), 32'h0);
    check("j3_drain_busy", 32'(busy), 32'h1);
    start = 1'b1; num_vecs = 16'd5;
    tick();
    start = 1'b0;
    dr_seen = 1'b0;
    wait_done(20, n);
    check("j3_done_lat", 32'(n), 32'd6);
    check("j3_no_dready", 32'(dr_seen), 32'h0);
    tick();
    check("j3_idle_busy", 32'(busy), 32'h0);
    check("j3_idle_done", 32'(done), 32'h0);

    // Job 4: reset in the middle of streaming, then a fresh job.
    start = 1'b1; num_vecs = 16'd3;
    tick();
    start = 1'b0;
    load_w(32'h01020304);
    d_valid = 1'b1; d_data = 32'h11223344;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0; d_valid = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      done_seen |= done;
    end
    check("midrst_no_done", 32'(done_seen), 32'h0);
    check("midrst_idle", 32'(busy), 32'h0);
    start = 1'b1; num_vecs = 16'd1;
    tick();
    start = 1'b0;
    load_w(32'h05060708);
    check("j5_dready", 32'(d_ready), 32'h1);
    d_valid = 1'b1; d_data = 32'h7F80FF01;
    tick();
    d_valid = 1'b0;
    check("j5_e0_data", sa_data, 32'h00000001);
    check("j5_e0_act", 32'(sa_active), 32'h1);
    wait_done(20, n);
    check("j5_done_lat", 32'(n), 32'd7);
    tick();

`ifdef SA_FEEDER_WREUSE_EN
    // Job 6: weight reuse skips the load phase entirely.
    start = 1'b1; num_vecs = 16'd1; keep_w = 1'b1;
    tick();
    start = 1'b0; keep_w = 1'b0;
    check("reuse_wready", 32'(w_ready), 32'h0);
    check("reuse_dready", 32'(d_ready), 32'h1);
    check("reuse_wwrite", 32'(sa_wwrite), 32'h0);
    d_valid = 1'b1; d_data = 32'h00000055;
    tick();
    d_valid = 1'b0;
    check("reuse_e0_data", sa_data, 32'h00000055);
    wwr_seen = 1'b0; wr_seen = 1'b0;
    wait_done(20, n);
    check("reuse_done_lat", 32'(n), 32'd7);
    check("reuse_no_wwrite", 32'(wwr_seen), 32'h0);
    check("reuse_no_wready", 32'(wr_seen), 32'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
SA_FEEDER -- requirements
Module: sa_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 4: systolic array rows, i.e. the number of datain lanes.
REQ-002 SHALL have parameter COLS, default 4: systolic array columns, i.e. the number of weight lanes.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request that begins a job.
REQ-006 SHALL have port num_vecs, input, 16 bits: number of data vectors to stream, sampled on an accepted start.
REQ-007 SHALL have ports w_valid (input, 1), w_data (input, 8*COLS, signed bytes) and w_ready (output, 1): weight-vector handshake.
REQ-008 SHALL have ports d_valid (input, 1), d_data (input, 8*ROWS, signed bytes, lane r = row r) and d_ready (output, 1): data-vector handshake.
REQ-009 SHALL have ports sa_win (output, 8*COLS) and sa_wwrite (output, 1): to the top-row PE win/wwrite inputs.
REQ-010 SHALL have ports sa_data (output, 8*ROWS) and sa_active (output, ROWS): to the left-column PE datain/active inputs.
REQ-011 SHALL have ports busy (output, 1) and done (output, 1): busy is high from an accepted start until done; done is a one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WLOAD, STREAM, DRAIN and FIN.
REQ-013 SHALL accept start only in IDLE; start is ignored in every other state.
REQ-014 SHALL go IDLE->WLOAD on an accepted start and latch num_vecs.
REQ-015 SHALL assert w_ready only in WLOAD; a transfer occurs when w_valid && w_ready.
REQ-016 SHALL, on a weight transfer, drive sa_win=w_data with sa_wwrite=1 on the next cycle; otherwise sa_wwrite=0 and sa_win holds its value.
REQ-017 SHALL leave WLOAD after exactly ROWS weight transfers, going to STREAM, or to DRAIN if num_vecs==0; a w_valid gap extends WLOAD but never reaches sa_wwrite.
REQ-018 SHALL assert d_ready only in STREAM; a transfer occurs when d_valid && d_ready.
REQ-019 SHALL present lane r of a transferred vector on sa_data lane r with sa_active[r]=1 exactly 1+r cycles after the transfer edge.
REQ-020 SHALL propagate a cycle with no transfer through the skew as a bubble: sa_active[r]=0 and sa_data lane r=0 at the matching skew slot.
REQ-021 SHALL go STREAM->DRAIN on the num_vecs-th transfer.
REQ-022 SHALL hold DRAIN for exactly ROWS+COLS-1 cycles with no new input, then enter FIN.
REQ-023 SHALL stay in FIN for one cycle with done=1, then return to IDLE.
REQ-024 SHALL use a 16-bit vector counter that counts up to num_vecs; num_vecs=65535 completes without wrap.
REQ-025 SHALL drive d_ready and w_ready combinationally from state only, never from the valid inputs.
REQ-026 SHALL register all sa_* outputs.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, force state to IDLE and clear all counters and skew registers.
REQ-028 SHALL reset outputs to: sa_win=0, sa_wwrite=0, sa_data=0, sa_active=0, busy=0, done=0, w_ready=0, d_ready=0.
REQ-029 SHALL, on reset mid-job, abort the job without emitting done; in-flight skewed data is discarded and sa_active=0 from the next cycle.

Configuration
REQ-030 SHALL use macro SA_FEEDER_WREUSE_EN: when defined, add input keep_w (1 bit); keep_w=1 on an accepted start skips WLOAD (goes to STREAM, or DRAIN if num_vecs==0) and sa_wwrite stays 0 for the job.
REQ-031 SHALL, when SA_FEEDER_WREUSE_EN is undefined, omit keep_w and always execute WLOAD.

Structure
REQ-032 SHALL take DATA_W=8, SUM_W=16 and the FSM state enum typedef from shared package sa_pkg.
REQ-033 SHALL use sub-module sa_skew_line (parameter DEPTH, carrying data plus active), instantiated once per row with DEPTH=r; DEPTH=0 is a pass-through of the common output register.

Verification
REQ-034 SHALL cover: ROWS=COLS=4, weights 1..4 presented back-to-back -> sa_wwrite high 4 consecutive cycles, sa_win=1,2,3,4.
REQ-035 SHALL cover: num_vecs=2, d_data lanes {10,20,30,40} then {11,21,31,41} -> row 3 shows 40 at +4 cycles and 41 at +5; done 7 cycles after the last transfer.
REQ-036 SHALL cover: d_valid low for 1 cycle between vectors -> a single active=0 bubble per lane, shifted by r in each lane.
REQ-037 SHALL cover: num_vecs=0 -> no d_ready, DRAIN 7 cycles, then a done pulse; start during busy is ignored.
REQ-038 SHALL cover: reset asserted mid-STREAM -> next cycle all outputs zero, no done pulse, and a new start works normally.
REQ-039 SHALL cover, with SA_FEEDER_WREUSE_EN defined: keep_w=1 -> w_ready never asserted and sa_wwrite stays 0.
